// File: rtl/udl_counter_if.sv
// Bus bundle for udl_counter: control strobes, load value and count output.
// The tc terminal-count signal exists only when UDL_COUNTER_TC_EN is defined.
interface udl_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             d_nu;
  logic             pl;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] cnt;
`ifdef UDL_COUNTER_TC_EN
  logic             tc;

  modport master (output en, d_nu, pl, pin, input  cnt, tc);
  modport slave  (input  en, d_nu, pl, pin, output cnt, tc);
`else
  modport master (output en, d_nu, pl, pin, input  cnt);
  modport slave  (input  en, d_nu, pl, pin, output cnt);
`endif
endinterface

// File: rtl/udl_counter.sv
// Synchronous up/down counter with parallel load; priority rst > pl > en.
// Optional registered terminal-count output tc under UDL_COUNTER_TC_EN.
module udl_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter logic [31:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  udl_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] RST_TRUNC = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES      = '1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_step;

  // Next value when counting; modular arithmetic gives the wrap-around.
  always_comb begin
    cnt_step = bus.d_nu ? (cnt_q - ONE) : (cnt_q + ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_TRUNC;
    end else if (bus.pl) begin
      cnt_q <= bus.pin;
    end else if (bus.en) begin
      cnt_q <= cnt_step;
    end
  end

  assign bus.cnt = cnt_q;

`ifdef UDL_COUNTER_TC_EN
  logic tc_q;

  // High only on the edge where counting (not load/reset) lands on the end value.
  always_ff @(posedge clk) begin
    if (rst || bus.pl || !bus.en) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= bus.d_nu ? (cnt_step == '0) : (cnt_step == ONES);
    end
  end

  assign bus.tc = tc_q;
`endif

endmodule

// File: tb/tb_udl_counter.sv
// Self-checking bench for udl_counter: vector table, counting sweeps and a
// randomized run against a behavioural model, all checked through a scoreboard queue.
module tb_udl_counter;

  localparam int unsigned WIDTH = 4;

  typedef struct {
    logic             rst;
    logic             en;
    logic             d_nu;
    logic             pl;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] exp_cnt;
    logic             exp_tc;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic             tc;
    string            name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  udl_counter_if #(.WIDTH(WIDTH)) bus ();

  udl_counter #(
    .WIDTH   (WIDTH),
    .RST_VAL (32'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[$];

  logic [WIDTH-1:0] m_cnt;
  logic             m_tc;

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: queue empty, got cnt %0d, expected an entry", bus.cnt);
      return;
    end
    x = sb.pop_front();
    check_val({x.name, " cnt"}, 32'(bus.cnt), 32'(x.cnt));
`ifdef UDL_COUNTER_TC_EN
    check_val({x.name, " tc"}, 32'(bus.tc), 32'(x.tc));
`endif
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic p,
                       input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] ec,
                       input logic et, input string nm);
    exp_t x;
    @(negedge clk);
    rst      = r;
    bus.en   = e;
    bus.d_nu = d;
    bus.pl   = p;
    bus.pin  = v;
    x.cnt  = ec;
    x.tc   = et;
    x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic add(input logic r, input logic e, input logic d, input logic p,
                     input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] ec, input logic et);
    vec_t t;
    t.rst = r; t.en = e; t.d_nu = d; t.pl = p; t.pin = v;
    t.exp_cnt = ec; t.exp_tc = et;
    vecs.push_back(t);
  endtask

  // Reference behaviour, advanced once per driven edge.
  task automatic model_step(input logic r, input logic e, input logic d, input logic p,
                            input logic [WIDTH-1:0] v);
    if (r) begin
      m_cnt = '0; m_tc = 1'b0;
    end else if (p) begin
      m_cnt = v; m_tc = 1'b0;
    end else if (e && d) begin
      m_cnt = m_cnt - 1; m_tc = (m_cnt == 0);
    end else if (e) begin
      m_cnt = m_cnt + 1; m_tc = (m_cnt == 15);
    end else begin
      m_tc = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.d_nu = 1'b0; bus.pl = 1'b0; bus.pin = '0;

    //   rst en dn pl pin  cnt tc
    add(1, 1, 0, 0, 11,  0, 0);  // reset overrides en
    add(1, 1, 0, 0, 11,  0, 0);
    add(1, 1, 0, 0, 11,  0, 0);
    add(0, 1, 0, 0, 11,  1, 0);  // up count
    add(0, 1, 0, 0, 11,  2, 0);
    add(0, 0, 0, 0, 11,  2, 0);  // hold
    add(0, 0, 0, 0, 11,  2, 0);
    add(0, 1, 0, 0, 11,  3, 0);  // resume
    add(0, 1, 0, 1, 11, 11, 0);  // load wins over en
    add(0, 1, 1, 0, 11, 10, 0);  // down
    add(0, 1, 1, 0, 11,  9, 0);
    add(0, 0, 0, 1, 15, 15, 0);  // load 15: no tc
    add(0, 1, 0, 0,  0,  0, 0);  // up wrap 15 -> 0
    add(0, 1, 0, 1,  0,  0, 0);  // load 0: no tc
    add(0, 1, 1, 0,  0, 15, 0);  // down wrap 0 -> 15
    add(0, 0, 0, 1, 13, 13, 0);
    add(0, 1, 0, 0,  0, 14, 0);
    add(0, 1, 0, 0,  0, 15, 1);  // counted into all-ones
    add(0, 1, 0, 0,  0,  0, 0);
    add(0, 0, 1, 1,  2,  2, 0);
    add(0, 1, 1, 0,  0,  1, 0);
    add(0, 1, 1, 0,  0,  0, 1);  // counted into zero
    add(0, 0, 1, 0,  0,  0, 0);  // held at zero: tc drops
    add(0, 1, 1, 0,  0, 15, 0);
    add(1, 1, 0, 1,  7,  0, 0);  // reset beats load
    add(0, 0, 0, 1,  5,  5, 0);  // load with en=0
    add(0, 1, 0, 0,  5,  6, 0);
    add(0, 1, 1, 0,  5,  5, 0);  // direction flip, no dead cycle
    add(0, 1, 0, 0,  5,  6, 0);
    add(0, 1, 1, 1,  1,  1, 0);
    add(1, 1, 1, 0,  1,  0, 0);  // reset to 0: no tc

    for (int unsigned i = 0; i < vecs.size(); i++)
      drive(vecs[i].rst, vecs[i].en, vecs[i].d_nu, vecs[i].pl, vecs[i].pin,
            vecs[i].exp_cnt, vecs[i].exp_tc, $sformatf("vec%0d", i));

    // Full up sweep and full down sweep from reset, each wrapping once.
    drive(1, 0, 0, 0, 0, 0, 0, "sweep_rst");
    for (int unsigned i = 1; i <= 17; i++)
      drive(0, 1, 0, 0, 0, 4'(i), (4'(i) == 4'd15), $sformatf("up%0d", i));
    drive(1, 0, 0, 0, 0, 0, 0, "sweep_rst2");
    for (int unsigned i = 1; i <= 17; i++)
      drive(0, 1, 1, 0, 0, 4'(16 - (i % 16)), (i == 16), $sformatf("dn%0d", i));

    // Randomized traffic against the model.
    m_cnt = '0; m_tc = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, "rand_rst");
    for (int unsigned i = 0; i < 300; i++) begin
      logic r, e, d, p;
      logic [WIDTH-1:0] v;
      r = ($urandom_range(0, 31) == 0);
      p = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 1) != 0;
      v = 4'($urandom_range(0, 15));
      model_step(r, e, d, p, v);
      drive(r, e, d, p, v, m_cnt, m_tc, $sformatf("rand%0d", i));
    end

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
